fir_main: RTL and testbench



---
 rtl/fir_pkg.sv | 37 +++
 rtl/fir_if.sv | 13 +
 rtl/fir_mac.sv | 29 ++
 rtl/fir_main.sv | 72 +++++++
 tb/tb_fir_main.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants, tap coefficients and output narrowing for the FIR.
// FIR_SAT_EN selects saturating (defined) or wrapping (undefined) fit().
package fir_pkg;

  localparam int TAPS  = 16;
  localparam int DW    = 8;
  localparam int OW    = 16;
  localparam int ACC_W = 21;
  localparam int PW    = 2 * DW;
  localparam int TW    = $clog2(TAPS);

  localparam logic signed [DW-1:0] COEFF [TAPS] = '{
    -8'sd3,  8'sd0,  8'sd8,  8'sd20,
     8'sd38, 8'sd58, 8'sd75, 8'sd85,
     8'sd85, 8'sd75, 8'sd58, 8'sd38,
     8'sd20, 8'sd8,  8'sd0,  -8'sd3
  };

  localparam logic signed [ACC_W-1:0] SMAX = 21'sd32767;
  localparam logic signed [ACC_W-1:0] SMIN = -21'sd32768;

  function automatic logic signed [OW-1:0] fit(
    input logic signed [ACC_W-1:0] v
  );
`ifdef FIR_SAT_EN
    if (v > SMAX)
      fit = 16'sh7fff;
    else if (v < SMIN)
      fit = 16'sh8000;
    else
      fit = OW'(v);
`else
    fit = OW'(v);
`endif
  endfunction

endpackage

// File: rtl/fir_if.sv
// Sample in / filtered out bundle between source, filter and capture.
// slave side is the filter, master side is the sample source/monitor.
interface fir_if;
  import fir_pkg::*;

  logic signed [DW-1:0] a;
  logic signed [OW-1:0] op;
  logic signed [OW-1:0] y;

  modport master (output a, input op, input y);
  modport slave  (input a, output op, output y);

endinterface

// File: rtl/fir_mac.sv
// Single shared 8x8 signed multiplier feeding a 21-bit accumulator.
// clr wins over en; 21 bits cover 16 full-scale products.
module fir_mac
  import fir_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [DW-1:0]    x,
  input  logic signed [DW-1:0]    c,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [PW-1:0] prod;

  assign prod = x * c;

  // Accumulate one tap product per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + ACC_W'(prod);
  end

endmodule

// File: rtl/fir_main.sv
// Time-multiplexed 16-tap FIR: one sample and one output per frame.
// FIR_SAT_EN (see fir_pkg) picks saturating vs wrapping output.
module fir_main
  import fir_pkg::*;
#(
  parameter int FRAME_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  fir_if.slave bus
);

  localparam int CW = $clog2(FRAME_CYCLES);

  logic [CW-1:0]        cnt;
  logic signed [DW-1:0] x [TAPS];
  logic [TW-1:0]        tap;
  logic                 mac_clr;
  logic                 mac_en;
  logic                 op_ld;
  logic signed [ACC_W-1:0] acc;
  logic signed [OW-1:0] op_q;

  assign tap     = TW'(cnt - CW'(1));
  assign mac_clr = (cnt == '0);
  assign mac_en  = (cnt != '0) && (cnt <= CW'(TAPS));
  assign op_ld   = (cnt == CW'(TAPS + 1));

  // Frame counter, wraps at the end of every sample period.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (cnt == CW'(FRAME_CYCLES - 1))
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  // Delay line shifts in the new sample at frame start only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++)
        x[i] <= '0;
    end else if (mac_clr) begin
      x[0] <= bus.a;
      for (int i = 1; i < TAPS; i++)
        x[i] <= x[i-1];
    end
  end

  fir_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .x     (x[tap]),
    .c     (COEFF[tap]),
    .acc   (acc)
  );

  // Output register captures the finished sum once per frame.
  always_ff @(posedge clk) begin
    if (reset)
      op_q <= '0;
    else if (op_ld)
      op_q <= fit(acc);
  end

  assign bus.op = op_q;
  assign bus.y  = fit(acc);

endmodule

// File: tb/tb_fir_main.sv
// Directed bench for fir_main: zero input, impulse, step with
// per-edge timing, mid-frame reset and overflow behaviour.
module tb_fir_main;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fir_if bus ();

  fir_main #(.FRAME_CYCLES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int pass_cnt = 0;
  int total    = 0;

  localparam int C [16] = '{
    -3, 0, 8, 20, 38, 58, 75, 85,
    85, 75, 58, 38, 20, 8, 0, -3
  };

  localparam int CUM [16] = '{
    -3, -3, 5, 25, 63, 121, 196, 281,
    366, 441, 499, 537, 557, 565, 565, 562
  };

`ifdef FIR_SAT_EN
  localparam int EXP_P127 = 32767;
  localparam int EXP_M128 = -32768;
`else
  localparam int EXP_P127 = 5838;
  localparam int EXP_M128 = -6400;
`endif

  task automatic check(
    input string              tag,
    input logic signed [31:0] obs,
    input logic signed [31:0] exp
  );
    total++;
    assert (obs === exp)
      pass_cnt++;
    else
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Entered at a negedge just before E0; leaves at the next one.
  task automatic run_frame(
    input logic signed [7:0] s,
    input logic signed [7:0] j,
    input bit                chk,
    input int                e,
    input string             tag
  );
    bus.a = s;
    @(posedge clk);
    #1 bus.a = j;
    repeat (63) @(posedge clk);
    @(negedge clk);
    if (chk) begin
      check({tag, "/op"}, bus.op, e);
      check({tag, "/y"}, bus.y, e);
    end
  endtask

  initial begin
    int lim;
    reset = 1'b1;
    bus.a = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/op", bus.op, 0);
    check("rst/y", bus.y, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++)
      run_frame(8'sd0, 8'sh5a, 1'b1, 0,
                $sformatf("zero%0d", i));

    run_frame(8'sd1, -8'sd77, 1'b1, C[0], "imp0");
    for (int i = 1; i < 17; i++)
      run_frame(8'sd0, 8'sd99, 1'b1,
                (i < 16) ? C[i] : 0,
                $sformatf("imp%0d", i));

    run_frame(8'sd1, 8'sd0, 1'b1, C[0], "rimp0");
    for (int i = 1; i < 5; i++)
      run_frame(8'sd0, 8'sd0, 1'b1, C[i],
                $sformatf("rimp%0d", i));
    bus.a = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst/op", bus.op, 0);
    check("midrst/y", bus.y, 0);
    @(negedge clk);
    reset = 1'b0;
    run_frame(8'sd0, 8'sd0, 1'b1, 0, "postrst0");
    run_frame(8'sd0, 8'sd0, 1'b1, 0, "postrst1");

    for (int f = 0; f < 18; f++) begin
      if (f == 4) begin
        bus.a = 8'sd10;
        @(posedge clk);
        #1 bus.a = -8'sd50;
        for (int k = 1; k <= 16; k++) begin
          @(posedge clk);
          #1;
          lim = (k - 1 < 4) ? k - 1 : 4;
          check($sformatf("tm/y%0d", k), bus.y, 10 * CUM[lim]);
          check($sformatf("tm/op%0d", k), bus.op, 250);
        end
        @(posedge clk);
        #1;
        check("tm/op17", bus.op, 630);
        repeat (46) @(posedge clk);
        @(negedge clk);
        check("tm/end", bus.op, 630);
      end else begin
        lim = (f < 15) ? f : 15;
        run_frame(8'sd10, -8'sd128, 1'b1, 10 * CUM[lim],
                  $sformatf("step%0d", f));
      end
    end

    for (int f = 0; f < 17; f++)
      run_frame(8'sd127, -8'sd1, f >= 15, EXP_P127,
                $sformatf("p127_%0d", f));

`ifdef FIR_SAT_EN
    for (int f = 0; f < 17; f++)
      run_frame(-8'sd128, 8'sd5, f >= 15, EXP_M128,
                $sformatf("m128_%0d", f));
`else
    for (int f = 0; f < 17; f++)
      run_frame(-8'sd128, 8'sd5, f >= 15, EXP_M128,
                $sformatf("m128w_%0d", f));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
